// File: rtl/irs_sample_mon_sequencer.sv
// ---------------------------------------------------------------------------
// irs_sample_mon_sequencer
//
// Drives the IRS sample-monitor scan protocol. On a start request it issues
// one begin pulse, then NBITS bit slots (TSA strobe high for TSA_HIGH cycles,
// low for SETTLE cycles so the capture register's 4-stage sync pipeline can
// settle, then one shift pulse), and finally one complete pulse that commits
// the captured word in the capture register.
//
// Parameters
//   NBITS     bit slots per scan (2..256)
//   TSA_HIGH  cycles tsa_o is held high per slot (>=1)
//   SETTLE    cycles tsa_o is low before shift_o (>=5)
//
// Ports
//   clk_i         in   1  system clock, rising edge
//   rst_n_i       in   1  asynchronous active-low reset (release expected
//                         synchronous to clk_i)
//   start_i       in   1  scan request, honoured only while idle
//   abort_i       in   1  cancel the scan in progress (wins over start_i)
//   continuous_i  in   1  only with IRS_SAMPLE_MON_CONTINUOUS_EN: chain the
//                         next scan straight after complete_o
//   tsa_o         out  1  TSA sampling strobe
//   begin_o       out  1  1-cycle pulse: clear capture bit address
//   shift_o       out  1  1-cycle pulse: capture current bit, advance address
//   complete_o    out  1  1-cycle pulse: commit working word
//   busy_o        out  1  high whenever a scan is in progress
//   bit_count_o   out  8  index of the current bit slot
//
// Build option
//   IRS_SAMPLE_MON_CONTINUOUS_EN  adds continuous_i; when it is high in the
//   complete cycle (and no abort) the next scan begins on the following cycle.
//
// All outputs are flops loaded from the decode of the next state, so each
// output equals a decode of the current state and no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module irs_sample_mon_sequencer #(
  parameter int NBITS    = 256,
  parameter int TSA_HIGH = 4,
  parameter int SETTLE   = 6
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       abort_i,
`ifdef IRS_SAMPLE_MON_CONTINUOUS_EN
  input  logic       continuous_i,
`endif
  output logic       tsa_o,
  output logic       begin_o,
  output logic       shift_o,
  output logic       complete_o,
  output logic       busy_o,
  output logic [7:0] bit_count_o
);

  // One down-counter times both the TSA-high and the settle phases, so it is
  // sized for the longer of the two.
  localparam int MAX_HOLD = (TSA_HIGH > SETTLE) ? TSA_HIGH : SETTLE;
  localparam int CW       = $clog2(MAX_HOLD + 1);

  localparam logic [CW-1:0] TSA_LOAD    = CW'(TSA_HIGH - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    LAST_BIT    = 8'(NBITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_TSA_HI   = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_COMPLETE = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [7:0]      bit_count_s;

  // Next-state, phase-counter and bit-index logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_count_s = bit_count_o;

    case (state_r)
      ST_IDLE: begin
        // Abort has priority over a simultaneous start request.
        if (start_i && !abort_i) begin
          state_s     = ST_BEGIN;
          bit_count_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BEGIN: begin
        if (abort_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_TSA_HI;
          cnt_s   = TSA_LOAD;
        end
      end

      ST_TSA_HI: begin
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_SETTLE;
          cnt_s   = SETTLE_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_SETTLE: begin
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_SHIFT;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_SHIFT: begin
        // The index stays on the last bit through COMPLETE; it only
        // advances when another slot follows.
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (bit_count_o == LAST_BIT) begin
          state_s = ST_COMPLETE;
        end else begin
          state_s     = ST_TSA_HI;
          cnt_s       = TSA_LOAD;
          bit_count_s = bit_count_o + 8'd1;
        end
      end

      ST_COMPLETE: begin
`ifdef IRS_SAMPLE_MON_CONTINUOUS_EN
        if (continuous_i && !abort_i) begin
          state_s     = ST_BEGIN;
          bit_count_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
`else
        state_s = ST_IDLE;
`endif
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, phase counter and bit index registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_count_o <= 8'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_count_o <= bit_count_s;
    end
  end

  // Strobe registers: loaded with the decode of the state being entered, so
  // they always mirror the current state without any input-to-output path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tsa_o      <= 1'b0;
      begin_o    <= 1'b0;
      shift_o    <= 1'b0;
      complete_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      tsa_o      <= (state_s == ST_TSA_HI);
      begin_o    <= (state_s == ST_BEGIN);
      shift_o    <= (state_s == ST_SHIFT);
      complete_o <= (state_s == ST_COMPLETE);
      busy_o     <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_irs_sample_mon_sequencer.sv
module tb_irs_sample_mon_sequencer;

  localparam int NBITS    = 256;
  localparam int TSA_HIGH = 4;
  localparam int SETTLE   = 6;
  localparam int SLOT     = TSA_HIGH + SETTLE + 1;
  // Offset (in cycles after the begin cycle) of the complete cycle.
  localparam int LASTP    = 1 + NBITS * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       tsa;
  logic       beg;
  logic       shift;
  logic       comp;
  logic       busy;
  logic [7:0] bc;
`ifdef IRS_SAMPLE_MON_CONTINUOUS_EN
  logic       cont = 1'b0;
`endif

  irs_sample_mon_sequencer #(
    .NBITS   (NBITS),
    .TSA_HIGH(TSA_HIGH),
    .SETTLE  (SETTLE)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .abort_i     (abort),
`ifdef IRS_SAMPLE_MON_CONTINUOUS_EN
    .continuous_i(cont),
`endif
    .tsa_o       (tsa),
    .begin_o     (beg),
    .shift_o     (shift),
    .complete_o  (comp),
    .busy_o      (busy),
    .bit_count_o (bc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] outv();
    return {tsa, beg, shift, comp, busy, bc};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) step();
    check("reset_outputs", 32'(outv()), 32'd0);
    rst_n = 1'b1;
    step();
    step();
  endtask

  // Scan statistics gathered by observe(); cycle 1 is the begin cycle.
  int first_begin, second_begin, begin_count, first_tsa, last_tsa0;
  int first_shift, shift_count, complete_count, complete_cyc, busy_fall;
  int overlap, stray, bc_probe, bc_seen;
  logic [NBITS-1:0] work;
  logic [NBITS-1:0] committed;
  logic [NBITS-1:0] pattern;

  // Bench-side capture register: the IRS returns bit i = i[0].
  task automatic observe(input int c);
    if (beg) begin
      begin_count++;
      if (first_begin < 0) first_begin = c;
      else if (second_begin < 0) second_begin = c;
      work = '0;
    end
    if (tsa) begin
      if (first_tsa < 0) first_tsa = c;
      if (shift_count == 0) last_tsa0 = c;
    end
    if (shift) begin
      if (first_shift < 0) first_shift = c;
      shift_count++;
      work[bc] = bc[0];
    end
    if (comp) begin
      complete_count++;
      complete_cyc = c;
      committed = work;
    end
    if (!busy && busy_fall < 0) busy_fall = c;
    if ($countones({tsa, beg, shift, comp}) > 1) overlap++;
    if (!busy && (tsa || beg || shift || comp)) stray++;
    if (c == bc_probe) bc_seen = 32'(bc);
  endtask

  task automatic run_scan(input int ncyc, input int abort_at, input int rst_at,
                          input int rst_rel, input bit hold);
    first_begin = -1; second_begin = -1; begin_count = 0; first_tsa = -1;
    last_tsa0 = -1; first_shift = -1; shift_count = 0; complete_count = 0;
    complete_cyc = -1; busy_fall = -1; overlap = 0; stray = 0; bc_seen = -1;
    start = 1'b1;
    abort = 1'b0;
    step();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      observe(c);
      abort = (c == abort_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outv()), 32'd0);
      end
      if (c == rst_rel) rst_n = 1'b1;
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic        a;
    logic [12:0] exp;   // {tsa, begin, shift, complete, busy, bit_count}
  } vec_t;

  vec_t vecs[20];

  bit          m_act;
  int          m_p;
  int          m_bc;
  int          q;
  int          r;
  logic        e_tsa, e_beg, e_shift, e_comp, e_busy;
  logic        rs, ra;

  initial begin
    // Cycle-by-cycle vectors straight after reset release.
    vecs[0]  = '{1'b1, 1'b1, 13'h0000};               // abort beats start
    vecs[1]  = '{1'b0, 1'b0, 13'h0000};
    vecs[2]  = '{1'b1, 1'b0, {5'b01001, 8'd0}};       // begin, cycle 1
    vecs[3]  = '{1'b0, 1'b0, {5'b10001, 8'd0}};       // tsa cycles 2..5
    vecs[4]  = '{1'b0, 1'b0, {5'b10001, 8'd0}};
    vecs[5]  = '{1'b0, 1'b0, {5'b10001, 8'd0}};
    vecs[6]  = '{1'b0, 1'b0, {5'b10001, 8'd0}};
    vecs[7]  = '{1'b0, 1'b0, {5'b00001, 8'd0}};       // settle cycles 6..11
    vecs[8]  = '{1'b0, 1'b0, {5'b00001, 8'd0}};
    vecs[9]  = '{1'b0, 1'b0, {5'b00001, 8'd0}};
    vecs[10] = '{1'b0, 1'b0, {5'b00001, 8'd0}};
    vecs[11] = '{1'b0, 1'b0, {5'b00001, 8'd0}};
    vecs[12] = '{1'b0, 1'b0, {5'b00001, 8'd0}};
    vecs[13] = '{1'b0, 1'b0, {5'b00101, 8'd0}};       // shift, cycle 12
    vecs[14] = '{1'b0, 1'b0, {5'b10001, 8'd1}};       // slot 1
    vecs[15] = '{1'b1, 1'b0, {5'b10001, 8'd1}};       // start ignored while busy
    vecs[16] = '{1'b0, 1'b1, {5'b00000, 8'd1}};       // abort: idle, index held
    vecs[17] = '{1'b0, 1'b0, {5'b00000, 8'd1}};
    vecs[18] = '{1'b1, 1'b0, {5'b01001, 8'd0}};       // new begin
    vecs[19] = '{1'b0, 1'b1, {5'b00000, 8'd0}};       // abort from begin

    for (int i = 0; i < NBITS; i++) pattern[i] = (i % 2 == 1);
    committed = '1;
    work = '0;
    bc_probe = -1;

    do_reset();
    for (int i = 0; i < 20; i++) begin
      start = vecs[i].s;
      abort = vecs[i].a;
      step();
      check($sformatf("vector_%0d", i), 32'(outv()), 32'(vecs[i].exp));
    end
    start = 1'b0;
    abort = 1'b0;

    // Full scan timing and committed word.
    do_reset();
    run_scan(2830, -1, -1, -1, 1'b0);
    check("t1_first_begin", 32'(first_begin), 32'd1);
    check("t1_begin_count", 32'(begin_count), 32'd1);
    check("t1_first_tsa", 32'(first_tsa), 32'd2);
    check("t1_last_tsa_slot0", 32'(last_tsa0), 32'd5);
    check("t1_first_shift", 32'(first_shift), 32'd12);
    check("t1_shift_count", 32'(shift_count), 32'(NBITS));
    check("t1_complete_count", 32'(complete_count), 32'd1);
    check("t1_complete_cycle", 32'(complete_cyc), 32'd2818);
    check("t1_busy_fall", 32'(busy_fall), 32'd2819);
    check("t1_overlap", 32'(overlap), 32'd0);
    check("t1_stray", 32'(stray), 32'd0);
    check("t1_word_low", committed[31:0], pattern[31:0]);
    check("t1_word_high", committed[NBITS-1 -: 32], pattern[NBITS-1 -: 32]);

    // Abort in cycle 500.
    bc_probe = 501;
    run_scan(600, 500, -1, -1, 1'b0);
    check("t3_busy_fall", 32'(busy_fall), 32'd501);
    check("t3_no_complete", 32'(complete_count), 32'd0);
    check("t3_shift_count", 32'(shift_count), 32'd45);
    check("t3_bit_count_held", 32'(bc_seen), 32'd45);
    check("t3_stray", 32'(stray), 32'd0);
    check("t3_word_kept", committed[31:0], pattern[31:0]);

    // start held high through a whole scan.
    do_reset();
    run_scan(2830, -1, -1, -1, 1'b1);
    check("t4_begin_count", 32'(begin_count), 32'd2);
    check("t4_second_begin", 32'(second_begin), 32'd2820);
    check("t4_busy_fall", 32'(busy_fall), 32'd2819);
    check("t4_complete_count", 32'(complete_count), 32'd1);

    // Reset in cycle 1000, then a fresh scan.
    do_reset();
    run_scan(1010, -1, 1000, 1005, 1'b0);
    check("t5_busy_fall", 32'(busy_fall), 32'd1001);
    check("t5_no_complete", 32'(complete_count), 32'd0);
    step();
    check("t5_idle_after_reset", 32'(outv()), 32'd0);
    committed = '0;
    run_scan(2830, -1, -1, -1, 1'b0);
    check("t5_complete_cycle", 32'(complete_cyc), 32'd2818);
    check("t5_shift_count", 32'(shift_count), 32'(NBITS));
    check("t5_word", committed[63:0], pattern[63:0]);

    // Random start/abort traffic against an offset-based reference model.
    do_reset();
    m_act = 1'b0;
    m_p = 0;
    m_bc = 0;
    for (int i = 0; i < 20000; i++) begin
      rs = ($urandom_range(0, 15) == 0);
      ra = ($urandom_range(0, 3999) == 0) || (m_act && $urandom_range(0, 49999) == 7);
      start = rs;
      abort = ra;
      step();
      if (!m_act) begin
        if (rs && !ra) begin
          m_act = 1'b1;
          m_p = 0;
        end
      end else if (ra || m_p == LASTP) begin
        m_act = 1'b0;
      end else begin
        m_p++;
      end
      {e_tsa, e_beg, e_shift, e_comp, e_busy} = 5'b00000;
      if (m_act) begin
        e_busy = 1'b1;
        if (m_p == 0) begin
          e_beg = 1'b1;
          m_bc = 0;
        end else if (m_p == LASTP) begin
          e_comp = 1'b1;
          m_bc = NBITS - 1;
        end else begin
          q = m_p - 1;
          m_bc = q / SLOT;
          r = q % SLOT;
          e_tsa = (r < TSA_HIGH);
          e_shift = (r == SLOT - 1);
        end
      end
      check("random_cycle", 32'(outv()),
            32'({e_tsa, e_beg, e_shift, e_comp, e_busy, 8'(m_bc)}));
    end
    start = 1'b0;
    abort = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
